// File: rtl/lane_wb_arbiter_pkg.sv
// Shared types and defaults for the vector-lane writeback arbiter.
// Row payloads are sized for the default lane geometry.
package lane_wb_arbiter_pkg;

    localparam int NUM_FU_DEF    = 4;
    localparam int SLICE_W_DEF   = 8;
    localparam int DATA_W_DEF    = 16;
    localparam int VREG_W_DEF    = 5;
    localparam int BUF_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_SQRT = 3'd1,
        FU_EXP  = 3'd2,
        FU_MUL  = 3'd3,
        FU_DIV  = 3'd4
    } fu_id_e;

    typedef struct packed {
        logic [VREG_W_DEF-1:0]                  vd;
        logic [SLICE_W_DEF-1:0][DATA_W_DEF-1:0] data;
        logic [SLICE_W_DEF-1:0]                 wen;
    } wb_row_t;

endpackage

// File: rtl/lane_wb_arbiter_if.sv
// Functional-unit element streams and register-file write port
// of the writeback arbiter.
interface lane_wb_arbiter_if
    import lane_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU  = NUM_FU_DEF,
    parameter int SLICE_W = SLICE_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int VREG_W  = VREG_W_DEF,
    parameter int IDX_W   = $clog2(SLICE_W),
    parameter int SRC_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);

    logic [NUM_FU-1:0]         fu_valid;
    logic [NUM_FU-1:0]         fu_ready;
    logic [NUM_FU*IDX_W-1:0]   fu_idx;
    logic [NUM_FU*DATA_W-1:0]  fu_data;
    logic [NUM_FU-1:0]         fu_mask;
    logic [NUM_FU*VREG_W-1:0]  fu_vd;
    logic [NUM_FU-1:0]         fu_last;

    logic                      wb_valid;
    logic                      wb_ready;
    logic [VREG_W-1:0]         wb_vd;
    logic [SLICE_W*DATA_W-1:0] wb_data;
    logic [SLICE_W-1:0]        wb_wen;
    logic [SRC_W-1:0]          wb_src;

    modport master (
        output fu_valid, fu_idx, fu_data,
        output fu_mask, fu_vd, fu_last,
        output wb_ready,
        input  fu_ready,
        input  wb_valid, wb_vd, wb_data,
        input  wb_wen, wb_src
    );

    modport slave (
        input  fu_valid, fu_idx, fu_data,
        input  fu_mask, fu_vd, fu_last,
        input  wb_ready,
        output fu_ready,
        output wb_valid, wb_vd, wb_data,
        output wb_wen, wb_src
    );

endinterface

// File: rtl/lane_wb_arbiter_fifo.sv
// Completed-row queue: circular buffer with wrap-around pointers.
// No bypass; push only when count < BUF_DEPTH, pop only when non-empty.
module lane_wb_arbiter_fifo
    import lane_wb_arbiter_pkg::*;
#(
    parameter int  BUF_DEPTH = BUF_DEPTH_DEF,
    parameter type T         = wb_row_t,
    parameter int  CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  T                 din,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    T                 mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] nxt(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lane_wb_arbiter.sv
// Vector-lane writeback: per-channel row assembly, row queues and a
// round-robin arbiter onto the register-file write port.
module lane_wb_arbiter
    import lane_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU    = NUM_FU_DEF,
    parameter int SLICE_W   = SLICE_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int VREG_W    = VREG_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int IDX_W     = $clog2(SLICE_W)
) (
    input logic CLK,
    input logic RST,
    lane_wb_arbiter_if.slave bus
);

    localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [VREG_W-1:0]              vd;
        logic [SLICE_W-1:0][DATA_W-1:0] data;
        logic [SLICE_W-1:0]             wen;
    } row_t;

    row_t              head [NUM_FU];
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] pop;

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  pick;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  lock_src;
    logic              lock;
    logic              any;
    logic              hs;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             acc;
        logic             push;
        logic [CNT_W-1:0] cnt;
        row_t             asm_r;
        row_t             mrg;
        row_t             hd;

        assign idx  = bus.fu_idx[i*IDX_W +: IDX_W];
        assign last = bus.fu_last[i];

        assign bus.fu_ready[i] =
            !RST && (cnt < CNT_W'(BUF_DEPTH));
        assign acc = bus.fu_valid[i] && bus.fu_ready[i];

        always_comb begin
            mrg           = asm_r;
            mrg.vd        = bus.fu_vd[i*VREG_W +: VREG_W];
            mrg.data[idx] = bus.fu_data[i*DATA_W +: DATA_W];
            mrg.wen[idx]  = bus.fu_mask[i];
        end

        // All-masked rows complete the op but never reach the queue.
        assign push = acc && last && (|mrg.wen);

        always_ff @(posedge CLK) begin
            if (RST) begin
                asm_r <= '0;
            end else if (acc) begin
                asm_r.vd   <= mrg.vd;
                asm_r.data <= mrg.data;
                asm_r.wen  <= last ? '0 : mrg.wen;
            end
        end

        lane_wb_arbiter_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .T         (row_t)
        ) u_fifo (
            .CLK   (CLK),
            .RST   (RST),
            .push  (push),
            .din   (mrg),
            .pop   (pop[i]),
            .head  (hd),
            .count (cnt)
        );

        assign head[i]     = hd;
        assign nonempty[i] = (cnt != '0);
    end

    always_comb begin
        int c;
        logic found;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            c = (int'(rr_ptr) + k) % NUM_FU;
            if (!found && nonempty[SRC_W'(c)]) begin
                found = 1'b1;
                pick  = SRC_W'(c);
            end
        end
    end

    // A stalled grant stays put so a late arrival cannot preempt it.
    assign grant = lock ? lock_src : pick;
    assign any   = |nonempty;
    assign hs    = any && bus.wb_ready;
    assign pop   = hs ? (NUM_FU'(1) << grant) : '0;

    assign bus.wb_valid = any;
    assign bus.wb_vd    = any ? head[grant].vd   : '0;
    assign bus.wb_data  = any ? head[grant].data : '0;
    assign bus.wb_wen   = any ? head[grant].wen  : '0;
    assign bus.wb_src   = any ? grant            : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_src <= '0;
        end else begin
            lock     <= any && !bus.wb_ready;
            lock_src <= grant;
            if (hs) begin
                rr_ptr <= (grant == SRC_W'(NUM_FU - 1))
                        ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lane_wb_arbiter.sv
// Directed bench for lane_wb_arbiter: vector table for row assembly,
// hand sequences for arbitration, backpressure and reset.
module tb_lane_wb_arbiter;
    import lane_wb_arbiter_pkg::*;

    typedef struct {
        int           ch;
        int           idx;
        logic [15:0]  data;
        bit           mask;
        int           vd;
        bit           last;
        logic         e_valid;
        logic [4:0]   e_vd;
        logic [7:0]   e_wen;
        logic [1:0]   e_src;
        logic [127:0] e_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    lane_wb_arbiter_if #(
        .NUM_FU(4), .SLICE_W(8), .DATA_W(16), .VREG_W(5)
    ) bus ();

    lane_wb_arbiter #(
        .NUM_FU(4), .SLICE_W(8), .DATA_W(16),
        .VREG_W(5), .BUF_DEPTH(2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    task automatic chk(string name, logic [127:0] act,
                       logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_wb(string name, logic v, logic [4:0] vd,
                          logic [7:0] wen, logic [1:0] src,
                          logic [127:0] data);
        chk({name, ".valid"}, 128'(bus.wb_valid), 128'(v));
        chk({name, ".vd"},    128'(bus.wb_vd),    128'(vd));
        chk({name, ".wen"},   128'(bus.wb_wen),   128'(wen));
        chk({name, ".src"},   128'(bus.wb_src),   128'(src));
        chk({name, ".data"},  bus.wb_data,        data);
    endtask

    // Row check where only element 0 is meaningful.
    task automatic chk_e0(string name, logic [4:0] vd,
                          logic [7:0] wen, logic [1:0] src,
                          logic [15:0] e0);
        chk({name, ".valid"}, 128'(bus.wb_valid), 128'd1);
        chk({name, ".vd"},    128'(bus.wb_vd),    128'(vd));
        chk({name, ".wen"},   128'(bus.wb_wen),   128'(wen));
        chk({name, ".src"},   128'(bus.wb_src),   128'(src));
        chk({name, ".e0"},    128'(bus.wb_data[15:0]), 128'(e0));
    endtask

    task automatic clear_in();
        bus.fu_valid = '0;
        bus.fu_idx   = '0;
        bus.fu_data  = '0;
        bus.fu_mask  = '0;
        bus.fu_vd    = '0;
        bus.fu_last  = '0;
    endtask

    task automatic put(int ch, int idx, logic [15:0] d,
                       bit m, int vd, bit l);
        bus.fu_valid[ch]          = 1'b1;
        bus.fu_idx[ch*3 +: 3]     = 3'(idx);
        bus.fu_data[ch*16 +: 16]  = d;
        bus.fu_mask[ch]           = m;
        bus.fu_vd[ch*5 +: 5]      = 5'(vd);
        bus.fu_last[ch]           = l;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(int ch, int idx, logic [15:0] d, bit m,
                       int vd, bit l, logic ev, logic [4:0] evd,
                       logic [7:0] ewen, logic [1:0] esrc,
                       logic [127:0] edata);
        vec_t v;
        v.ch = ch; v.idx = idx; v.data = d; v.mask = m;
        v.vd = vd; v.last = l; v.e_valid = ev; v.e_vd = evd;
        v.e_wen = ewen; v.e_src = esrc; v.e_data = edata;
        vecs.push_back(v);
    endtask

    task automatic rr_batch(int base);
        clear_in();
        for (int c = 0; c < 4; c++)
            put(c, 0, 16'(base + c), 1'b1, c + 1, 1'b1);
        step();
        clear_in();
        for (int c = 0; c < 4; c++) begin
            chk_e0($sformatf("rr%0h_%0d", base, c), 5'(c + 1),
                   8'h01, 2'(c), 16'(base + c));
            if (c < 3) step();
        end
    endtask

    initial begin
        // Full row on ALU channel, in-order indices.
        for (int i = 0; i < 8; i++)
            add(int'(FU_ALU), i, 16'(16'h10 + i), 1'b1, 3, i == 7,
                i == 7, (i == 7) ? 5'd3 : 5'd0,
                (i == 7) ? 8'hFF : 8'h00, 2'd0,
                (i == 7) ? 128'h0017_0016_0015_0014_0013_0012_0011_0010
                         : 128'h0);
        // Tail-masked row on channel 1.
        for (int i = 0; i < 8; i++)
            add(1, i, 16'(16'h20 + i), i < 5, 5, i == 7,
                i == 7, (i == 7) ? 5'd5 : 5'd0,
                (i == 7) ? 8'h1F : 8'h00, (i == 7) ? 2'd1 : 2'd0,
                (i == 7) ? 128'h0027_0026_0025_0024_0023_0022_0021_0020
                         : 128'h0);
        // Fully masked op on channel 2 never writes back.
        for (int i = 0; i < 8; i++)
            add(2, i, 16'(16'h30 + i), 1'b0, 7, i == 7,
                1'b0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(-1, 0, 16'h0, 1'b0, 0, 1'b0, 1'b0, 5'd0, 8'h00, 2'd0, 128'h0);
        // Out-of-order indices with an overwrite on channel 3.
        add(3, 7, 16'h0077, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 2, 16'h00AA, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 2, 16'h00BB, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 0, 16'h00A0, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 1, 16'h00A1, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 3, 16'h00A3, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 4, 16'h00A4, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 5, 16'h00A5, 1, 9, 0, 0, 5'd0, 8'h00, 2'd0, 128'h0);
        add(3, 6, 16'h00A6, 1, 9, 1, 1, 5'd9, 8'hFF, 2'd3,
            128'h0077_00A6_00A5_00A4_00A3_00BB_00A1_00A0);

        rst = 1'b1;
        bus.wb_ready = 1'b0;
        clear_in();
        repeat (2) @(negedge clk);
        chk("rst.fu_ready", 128'(bus.fu_ready), 128'h0);
        chk_wb("rst", 0, 5'd0, 8'h00, 2'd0, 128'h0);
        rst = 1'b0;
        #1;
        chk("post_rst.fu_ready", 128'(bus.fu_ready), 128'hF);
        bus.wb_ready = 1'b1;

        foreach (vecs[n]) begin
            clear_in();
            if (vecs[n].ch >= 0)
                put(vecs[n].ch, vecs[n].idx, vecs[n].data,
                    vecs[n].mask, vecs[n].vd, vecs[n].last);
            step();
            chk_wb($sformatf("vec%0d", n), vecs[n].e_valid,
                   vecs[n].e_vd, vecs[n].e_wen, vecs[n].e_src,
                   vecs[n].e_data);
            chk($sformatf("vec%0d.fu_ready", n),
                128'(bus.fu_ready), 128'hF);
        end

        // Round robin: two batches, each drained 0,1,2,3.
        rr_batch(16'h100);
        rr_batch(16'h200);
        step();
        chk("rr_done.valid", 128'(bus.wb_valid), 128'h0);

        // Backpressure on channel 0 with a depth-2 queue.
        bus.wb_ready = 1'b0;
        put(0, 0, 16'h0301, 1'b1, 2, 1'b1);
        step();
        put(0, 0, 16'h0302, 1'b1, 2, 1'b1);
        step();
        chk("bp.full", 128'(bus.fu_ready[0]), 128'h0);
        put(0, 0, 16'h0303, 1'b1, 2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk_e0($sformatf("bp_hold%0d", k), 5'd2, 8'h01,
                   2'd0, 16'h0301);
        end
        chk("bp.still_full", 128'(bus.fu_ready[0]), 128'h0);
        bus.wb_ready = 1'b1;
        step();
        chk("bp.ready_back", 128'(bus.fu_ready[0]), 128'h1);
        chk_e0("bp_row2", 5'd2, 8'h01, 2'd0, 16'h0302);
        step();
        clear_in();
        chk_e0("bp_row3", 5'd2, 8'h01, 2'd0, 16'h0303);
        step();
        chk("bp_done.valid", 128'(bus.wb_valid), 128'h0);

        // Stalled grant on ch3 must not be preempted by ch1 (rr_ptr=1).
        bus.wb_ready = 1'b0;
        put(3, 0, 16'h0403, 1'b1, 6, 1'b1);
        step();
        clear_in();
        chk_e0("lock_a", 5'd6, 8'h01, 2'd3, 16'h0403);
        put(1, 0, 16'h0401, 1'b1, 8, 1'b1);
        step();
        clear_in();
        for (int k = 0; k < 3; k++) begin
            chk_e0($sformatf("lock_hold%0d", k), 5'd6, 8'h01,
                   2'd3, 16'h0403);
            step();
        end
        bus.wb_ready = 1'b1;
        step();
        chk_e0("lock_next", 5'd8, 8'h01, 2'd1, 16'h0401);
        step();
        chk("lock_done.valid", 128'(bus.wb_valid), 128'h0);

        // Reset with queued rows and a partial row on channel 1.
        bus.wb_ready = 1'b0;
        put(0, 0, 16'h0501, 1'b1, 1, 1'b1);
        put(2, 0, 16'h0502, 1'b1, 1, 1'b1);
        put(1, 0, 16'h05A0, 1'b1, 4, 1'b0);
        step();
        clear_in();
        put(1, 1, 16'h05A1, 1'b1, 4, 1'b0);
        step();
        clear_in();
        chk("pre_rst.valid", 128'(bus.wb_valid), 128'h1);
        rst = 1'b1;
        step();
        chk("mid_rst.fu_ready", 128'(bus.fu_ready), 128'h0);
        chk_wb("mid_rst", 0, 5'd0, 8'h00, 2'd0, 128'h0);
        rst = 1'b0;
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst%0d.valid", k),
                128'(bus.wb_valid), 128'h0);
        end
        put(1, 5, 16'h0055, 1'b1, 4, 1'b1);
        step();
        clear_in();
        chk_wb("fresh", 1, 5'd4, 8'h20, 2'd1,
               128'h0000_0000_0055_0000_0000_0000_0000_0000);
        step();
        chk("fresh_done.valid", 128'(bus.wb_valid), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_wb_arbiter.md
Name: lane_wb_arbiter

Overview:
- Parametrised writeback stage for a vector lane with NUM_FU functional-unit channels (ALU, SQRT, EXP, MUL, DIV, ...).
- Each channel streams masked, element-indexed results. A per-channel assembler packs them into full slice rows.
- Completed rows queue per channel. A round-robin arbiter drains one row per handshake to the lane register-file write port.
- Generalises the single-FU, fixed-slice writeback path to N channels with buffering, per-element write enables and backpressure.

Parameters:
- NUM_FU, 4, number of functional-unit channels.
- SLICE_W, 8, elements per slice row.
- DATA_W, 16, bits per element.
- VREG_W, 5, destination vector register index width.
- BUF_DEPTH, 2, completed-row queue depth per channel (>=1).
- IDX_W, $clog2(SLICE_W), element index width (derived).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- fu_valid  in  NUM_FU  channel i presents an element.
- fu_ready  out  NUM_FU  channel i element accepted this cycle when valid&ready.
- fu_idx  in  NUM_FU*IDX_W  element position within row.
- fu_data  in  NUM_FU*DATA_W  element result.
- fu_mask  in  NUM_FU  1 = element active (written), 0 = masked/tail.
- fu_vd  in  NUM_FU*VREG_W  destination register; constant across one op.
- fu_last  in  NUM_FU  final element of the op on this channel.
- wb_valid  out  1  row available.
- wb_ready  in  1  register file accepts the row.
- wb_vd  out  VREG_W  destination register of the row.
- wb_data  out  SLICE_W*DATA_W  row data; element k at bits [k*DATA_W +: DATA_W].
- wb_wen  out  SLICE_W  per-element write enable.
- wb_src  out  $clog2(NUM_FU)  granted channel (debug/scoreboard release).

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset:
  - All queues empty; assembler wen cleared and data zeroed; rr_ptr=0.
  - wb_valid=0, wb_vd=0, wb_data=0, wb_wen=0, wb_src=0.
  - fu_ready=0 while RST=1.
  - Reset mid-operation discards partial rows and queued rows with no writeback.
- fu_ready[i] = !RST && (count[i] < BUF_DEPTH). Combinational from registered count only; no dependence on fu_valid.
- Element accept (valid&ready on channel i):
  - asm_data[i][fu_idx] <= fu_data.
  - asm_wen[i][fu_idx] <= fu_mask.
  - asm_vd[i] <= fu_vd.
  - A repeated idx within one op overwrites (last wins).
- Row completion: accept with fu_last=1.
  - Row = assembler contents merged with the current element.
  - If merged wen != 0, push {vd, data, wen} into queue i. If all-masked, discard (no writeback).
  - Assembler wen cleared the same cycle. Next accepted element starts a new row.
- Queue: circular buffer of BUF_DEPTH with wrap-around pointers and count 0..BUF_DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - No bypass: a full queue stays not-ready even if popped that cycle.
- Arbiter (round-robin):
  - Candidates = channels with count>0. Search starts at rr_ptr, wraps modulo NUM_FU.
  - wb_* driven combinationally from the granted queue head. wb_valid = any candidate.
  - Grant held stable while wb_valid && !wb_ready. A newly non-empty channel cannot preempt.
  - On handshake: pop the granted queue; rr_ptr <= grant+1 (wraps).
  - wb_data/wb_wen/wb_vd/wb_src = 0 when wb_valid=0.
- Latency: row completed at accept cycle t gives wb_valid at t+1 (queue previously empty, no contention).
- Throughput: 1 row/cycle aggregate; 1 element/cycle per channel.

Decomposition:
- vector_pkg gains:
  - wb_row_t {vd, data[SLICE_W], wen}.
  - fu_id_e channel enumeration (ALU=0, SQRT, EXP, MUL, DIV).
  - Default NUM_FU/BUF_DEPTH constants.
- Sub-module wb_row_fifo (parametrised BUF_DEPTH, wb_row_t payload), instantiated NUM_FU times.
- Assembler and round-robin arbiter stay in lane_wb_arbiter.

Test Plan:
- Single channel: ch0 sends idx 0..7, data 0x10+idx, mask=1, vd=3, last on idx7 -> next cycle wb_valid=1, wb_vd=3, wb_wen=0xFF, element k=0x10+k, wb_src=0.
- Masked/tail: ch1 sends idx0..4 mask=1, idx5..7 mask=0 -> wb_wen=0x1F. All-masked op on ch2 -> no wb_valid ever.
- Round robin: ch0..3 each complete a row the same cycle, wb_ready=1 -> wb_src sequence 0,1,2,3. Second batch with rr_ptr=0 -> 0,1,2,3 again, no starvation.
- Backpressure: wb_ready=0, ch0 completes 3 rows (BUF_DEPTH=2) -> fu_ready[0]=0 after 2 rows. Held wb_* constant and wb_src unchanged for 10 cycles. Raise wb_ready -> rows drain in order, fu_ready[0] returns 1 one cycle after first pop.
- Out-of-order idx/overwrite: ch3 sends idx 7,2,2(data 0xAA then 0xBB),0..., last -> element2=0xBB, all indices placed correctly.
- Reset mid-op: 2 rows queued plus partial row on ch1, assert RST 1 cycle -> wb_valid=0, fu_ready=0 during RST. After RST no stale row appears; a fresh op writes back correctly.
